// File: rtl/sr_ff_bist.sv
// Self-test driver/checker for a clocked SR flip-flop: walks hold/set/reset steps, counts q/qb mismatches.
// Define SR_BIST_INVALID_EN to append an unchecked (1,1) step followed by a recovery reset step.
module sr_ff_bist #(
  parameter int NUM_LOOPS = 4,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             q_i,
  input  logic             qb_i,
  output logic             s_o,
  output logic             r_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [2:0]       fail_step
);

`ifdef SR_BIST_INVALID_EN
  localparam logic [2:0] LAST_STEP = 3'd6;
`else
  localparam logic [2:0] LAST_STEP = 3'd4;
`endif
  localparam logic [7:0] LAST_LOOP = 8'(NUM_LOOPS - 1);
  localparam logic [2:0] NO_FAIL   = 3'd7;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t     state_reg;
  logic [2:0] step_reg;
  logic [7:0] loop_reg;

  // {s, r} driven during a step
  function automatic logic [1:0] step_drive(input logic [2:0] idx);
    case (idx)
      3'd0:    step_drive = 2'b01;
      3'd1:    step_drive = 2'b00;
      3'd2:    step_drive = 2'b10;
      3'd3:    step_drive = 2'b00;
      3'd4:    step_drive = 2'b01;
`ifdef SR_BIST_INVALID_EN
      3'd5:    step_drive = 2'b11;
      3'd6:    step_drive = 2'b01;
`endif
      default: step_drive = 2'b00;
    endcase
  endfunction

  // {expected q, check enable}; the invalid step is never checked
  function automatic logic [1:0] step_check(input logic [2:0] idx);
    case (idx)
      3'd0:    step_check = 2'b01;
      3'd1:    step_check = 2'b01;
      3'd2:    step_check = 2'b11;
      3'd3:    step_check = 2'b11;
      3'd4:    step_check = 2'b01;
`ifdef SR_BIST_INVALID_EN
      3'd5:    step_check = 2'b00;
      3'd6:    step_check = 2'b01;
`endif
      default: step_check = 2'b00;
    endcase
  endfunction

  logic       last_step;
  logic       last_loop;
  logic       mismatch;
  logic [2:0] next_idx;
  logic [1:0] cur_chk;
  logic [1:0] next_drv;

  always_comb begin
    cur_chk   = step_check(step_reg);
    last_step = (step_reg == LAST_STEP);
    last_loop = (loop_reg == LAST_LOOP);
    next_idx  = (state_reg == CHECK && !last_step) ? step_reg + 3'd1 : 3'd0;
    next_drv  = step_drive(next_idx);
    mismatch  = cur_chk[0] && ((q_i != cur_chk[1]) || (qb_i == q_i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
      loop_reg  <= 8'd0;
      s_o       <= 1'b0;
      r_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      fail_step <= NO_FAIL;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // error state is deliberately left frozen for inspection
        state_reg <= IDLE;
        s_o       <= 1'b0;
        r_o       <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg  <= APPLY;
              step_reg   <= 3'd0;
              loop_reg   <= 8'd0;
              err_cnt    <= '0;
              fail_step  <= NO_FAIL;
              pass       <= 1'b0;
              busy       <= 1'b1;
              {s_o, r_o} <= next_drv;
            end
          end
          APPLY:  state_reg <= SETTLE;
          SETTLE: state_reg <= CHECK;
          CHECK: begin
            if (mismatch) begin
              if (!(&err_cnt)) err_cnt <= err_cnt + 1'b1;
              if (fail_step == NO_FAIL) fail_step <= step_reg;
            end
            if (last_step && last_loop) begin
              state_reg <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              pass      <= (err_cnt == '0) && !mismatch;
              s_o       <= 1'b0;
              r_o       <= 1'b0;
            end else begin
              state_reg  <= APPLY;
              step_reg   <= next_idx;
              {s_o, r_o} <= next_drv;
              if (last_step) loop_reg <= loop_reg + 8'd1;
            end
          end
          DONE:    state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sr_ff_bist.sv
// Self-checking bench for sr_ff_bist: behavioural SR flip-flop with injectable faults, run table plus corner sequences.
module tb_sr_ff_bist;
  localparam int NL = 4;
`ifdef SR_BIST_INVALID_EN
  localparam int NSTEPS = 7;
  localparam int NCHK   = 6;
  localparam bit INV_ON = 1'b1;
`else
  localparam int NSTEPS = 5;
  localparam int NCHK   = 5;
  localparam bit INV_ON = 1'b0;
`endif
  // cycles counted inclusively from the first APPLY cycle to the done cycle
  localparam int RUN_LEN = NL * NSTEPS * 3 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic q_i, qb_i, s_o, r_o, busy, done, pass;
  logic [7:0] err_cnt;
  logic [2:0] fail_step;
  logic s3, r3, busy3, done3, pass3;
  logic [2:0] err3, fail3;

  always #5 clk = ~clk;

  // mode 0: ideal, 1: q stuck at 0, 2: qb tied to q
  int   mode = 0;
  logic ff_q = 1'b0;
  logic ff_inv = 1'b0;
  always @(posedge clk) begin
    ff_inv <= s_o & r_o;
    if (s_o & ~r_o)      ff_q <= 1'b1;
    else if (~s_o & r_o) ff_q <= 1'b0;
    else if (s_o & r_o)  ff_q <= 1'b0;
  end
  assign q_i  = (mode == 1) ? 1'b0 : ff_q;
  assign qb_i = (mode == 1) ? 1'b1 : (mode == 2) ? ff_q : (ff_inv ? 1'b0 : ~ff_q);

  sr_ff_bist #(.NUM_LOOPS(NL), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q_i(q_i), .qb_i(qb_i),
    .s_o(s_o), .r_o(r_o), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_step(fail_step));

  sr_ff_bist #(.NUM_LOOPS(NL), .ERR_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .q_i(1'b0), .qb_i(1'b1),
    .s_o(s3), .r_o(r3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_step(fail3));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int mode;
    int restart_at;
    int err;
    int fail;
    bit pass;
  } vec_t;

  typedef struct {
    int err;
    int fail;
    bit pass;
    int len;
    bit both_seen;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[4];

  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t g;
    int   k;
    bit   seen;
    mode = v.mode;
    e = '{v.err, v.fail, v.pass, RUN_LEN, INV_ON};
    @(negedge clk);
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    k = 1;
    seen = 1'b0;
    check("busy_after_start", busy, 1);
    while (!done && k < 1000) begin
      if (s_o && r_o) seen = 1'b1;
      start = (k == v.restart_at);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    g = sb.pop_front();
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: no done after %0d cycles, expected %0d", k, g.len);
    end else begin
      $display("run mode=%0d len=%0d err_cnt=%0d fail_step=%0d pass=%0d", v.mode, k, err_cnt, fail_step, pass);
      check("run_len", k, g.len);
      check("err_cnt", err_cnt, g.err);
      check("fail_step", fail_step, g.fail);
      check("pass", pass, g.pass);
      check("busy_at_done", busy, 0);
      check("s_and_r_seen", seen, g.both_seen);
      check("sat_done", done3, 1);
      check("sat_err_cnt", err3, 7);
      check("sat_fail_step", fail3, 2);
      check("sat_pass", pass3, 0);
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("s_o_idle", s_o, 0);
      check("r_o_idle", r_o, 0);
      check("pass_held", pass, g.pass);
      check("sat_busy_idle", busy3, 0);
      check("sat_drive_idle", {s3, r3}, 0);
    end
  endtask

  initial begin
    int k_abort;
    int k_rst;
    bit seen_done;
    vecs[0] = '{0, 0, 0, 7, 1'b1};
    vecs[1] = '{1, 0, 2 * NL, 2, 1'b0};
    vecs[2] = '{2, 0, NCHK * NL, 0, 1'b0};
    vecs[3] = '{1, 20, 2 * NL, 2, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_s_o", s_o, 0);
    check("rst_r_o", r_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_fail_step", fail_step, 7);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // abort in the SETTLE cycle of loop 1 step 2 (SET step)
    mode = 0;
    k_abort = (NSTEPS + 2) * 3 + 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k_abort - 1) @(negedge clk);
    check("s_o_before_abort", s_o, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort at cycle %0d: busy=%0d s_o=%0d r_o=%0d", k_abort, busy, s_o, r_o);
    check("abort_busy", busy, 0);
    check("abort_s_o", s_o, 0);
    check("abort_r_o", r_o, 0);
    check("abort_done", done, 0);
    check("abort_pass", pass, 0);
    check("abort_err_cnt", err_cnt, 0);
    check("abort_fail_step", fail_step, 7);
    seen_done = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_abort", seen_done, 0);
    run_vec(vecs[0]);

    // abort and start together in IDLE: start must be dropped
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    $display("abort+start in idle: busy=%0d", busy);
    check("abort_start_busy", busy, 0);
    repeat (5) @(negedge clk);
    check("abort_start_busy_later", busy, 0);
    check("abort_start_s_o", s_o, 0);

    // asynchronous reset during loop 2 step 2 with a stuck-at-0 cell
    mode = 1;
    k_rst = (2 * NSTEPS + 2) * 3 + 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (k_rst - 1) @(negedge clk);
    check("pre_rst_err_cnt", err_cnt, 4);
    check("pre_rst_fail_step", fail_step, 2);
    check("pre_rst_s_o", s_o, 1);
    rst_n = 1'b0;
    #1;
    $display("reset mid-run: s_o=%0d busy=%0d err_cnt=%0d fail_step=%0d", s_o, busy, err_cnt, fail_step);
    check("midrst_s_o", s_o, 0);
    check("midrst_r_o", r_o, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_fail_step", fail_step, 7);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
